axis_stream_arbiter: RTL and testbench
======================================

Name: axis_stream_arbiter

Overview:
Packet-granular round-robin arbiter that shares one AXI-Stream processing datapath (pass-through / byte-reverse / add-constant engine) between NUM_SRC requesters. Each requester supplies its own stream plus its own mode and constant_value. The arbiter grants one source per packet and routes that source's stream to the datapath input. It latches the source's mode/constant so that both are stable for the whole packet. It sits directly in front of the datapath's s_axis/mode/constant_value inputs.

Parameters:
TDATA_WIDTH, 32, stream data width in bits (multiple of 8)
NUM_SRC, 4, number of requesters (2..8)
MAX_PACKET_LEN, 10, maximum beats per granted packet before forced termination
ID_W, $clog2(NUM_SRC), width of grant index

Ports:
aclk  in  1  clock
areset  in  1  asynchronous, active-high reset
s_axis_tdata  in  NUM_SRC*TDATA_WIDTH  source data, source i at bits [i*TDATA_WIDTH +: TDATA_WIDTH]
s_axis_tkeep  in  NUM_SRC*TDATA_WIDTH/8  source byte enables
s_axis_tlast  in  NUM_SRC  source end-of-packet
s_axis_tvalid  in  NUM_SRC  source valid
s_axis_tready  out  NUM_SRC  source ready
src_mode  in  2*NUM_SRC  per-source mode (0 pass, 1 byte-reverse, 2 add-constant, 3 treated by datapath as pass)
src_constant  in  NUM_SRC*TDATA_WIDTH  per-source constant_value
m_axis_tdata  out  TDATA_WIDTH  to datapath
m_axis_tkeep  out  TDATA_WIDTH/8  to datapath
m_axis_tlast  out  1  to datapath
m_axis_tvalid  out  1  to datapath
m_axis_tready  in  1  from datapath
m_mode  out  2  latched mode of granted source
m_constant_value  out  TDATA_WIDTH  latched constant of granted source
grant_id  out  ID_W  index of current/last grant
busy  out  1  high in XFER
err_overlength  out  1  one-cycle pulse on forced termination

Behaviour:
- Reset (async, areset=1): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, m_mode=0, m_constant_value=0, busy=0, err_overlength=0. All s_axis_tready=0, m_axis_tvalid=0, and m_axis_tdata/tkeep/tlast=0. Reset mid-packet abandons the packet; the datapath sees tvalid drop immediately. No beat is completed during reset.
- States: IDLE, XFER.
- IDLE: all tready=0, m_axis_tvalid=0. If any s_axis_tvalid is set, select the first asserted index scanning rr_ptr, rr_ptr+1, ... (mod NUM_SRC). On that clock edge, latch grant_id, m_mode=src_mode[sel], and m_constant_value=src_constant[sel], clear beat_cnt, then go to XFER. Grant latency is 1 cycle from tvalid seen in IDLE.
- XFER: combinational route. m_axis_tdata/tkeep/tvalid come from source grant_id. s_axis_tready[grant_id]=m_axis_tready; all other tready=0. m_axis_tlast = s_tlast[grant_id] OR (beat_cnt==MAX_PACKET_LEN-1).
- A beat is accepted when m_axis_tvalid && m_axis_tready. Each accepted beat increments beat_cnt.
- An accepted beat with m_axis_tlast=1 ends the packet: next state IDLE, rr_ptr=grant_id+1 (wraps to 0 at NUM_SRC).
- There is a 1-cycle bubble between packets, including back-to-back from the same source.
- Forced termination: if the final beat is accepted because beat_cnt reached MAX_PACKET_LEN-1 while the source tlast=0, pulse err_overlength for 1 cycle. The source's remaining beats are arbitrated as a new packet.
- Backpressure: with m_axis_tready=0, hold state and grant; data passes unchanged; the source holds per AXI rules.
- Granted source dropping tvalid mid-packet: stay in XFER with the grant held. There is no timeout.
- src_mode/src_constant changes during XFER are ignored until the next grant.
- Simultaneous requests: strict round-robin from rr_ptr. The source just served has lowest priority.
- busy=1 exactly while state=XFER.

Test Plan:
- Single source: src0 mode=1, sends 1-beat packet 0x12345678 tlast=1 -> m_axis beat 0x12345678 with m_mode=1 one cycle after tvalid; grant_id=0; return to IDLE; rr_ptr=1.
- Fairness: all 4 sources continuously valid with 2-beat packets -> grant order 0,1,2,3,0. Each packet is contiguous with no interleaving, separated by one idle cycle.
- Config latch: src2 mode=2, constant=0x5; change to constant 0xFFFFFFFF after first beat of a 3-beat packet -> m_constant_value stays 0x00000005 for all 3 beats.
- Backpressure: m_axis_tready=0 for 3 cycles mid-packet -> tdata/grant stable; non-granted tready=0; beat count totals exactly the packet length once ready returns.
- Overlength: src1 sends 12 beats with tlast only on the 12th -> beat 10 carries m_axis_tlast=1 and err_overlength pulses once. Beats 11-12 are re-granted as a new packet after other pending sources.
- Reset mid-packet: areset=1 during beat 2 of src3 -> tvalid/tready drop immediately. After release: IDLE, rr_ptr=0, m_mode=0, m_constant_value=0; the next request from src0 is granted first.

Source files
------------

// File: rtl/axis_stream_arbiter.sv
// Packet-granular round-robin arbiter that shares one AXI-Stream datapath between NUM_SRC requesters.
// The granted stream is routed combinationally; its mode/constant are latched at grant time for the whole packet.
module axis_stream_arbiter #(
  parameter int TDATA_WIDTH    = 32,
  parameter int NUM_SRC        = 4,
  parameter int MAX_PACKET_LEN = 10,
  parameter int ID_W           = $clog2(NUM_SRC)
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_SRC*TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]              s_axis_tlast,
  input  logic [NUM_SRC-1:0]              s_axis_tvalid,
  output logic [NUM_SRC-1:0]              s_axis_tready,
  input  logic [2*NUM_SRC-1:0]            src_mode,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]  src_constant,
  output logic [TDATA_WIDTH-1:0]          m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]        m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [1:0]                      m_mode,
  output logic [TDATA_WIDTH-1:0]          m_constant_value,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy,
  output logic                            err_overlength
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(MAX_PACKET_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_PACKET_LEN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [1:0]             mode_q, mode_d;
  logic [TDATA_WIDTH-1:0] const_q, const_d;
  logic                   err_q, err_d;

  logic [TDATA_WIDTH-1:0] src_data_a  [NUM_SRC];
  logic [KEEP_W-1:0]      src_keep_a  [NUM_SRC];
  logic [1:0]             src_mode_a  [NUM_SRC];
  logic [TDATA_WIDTH-1:0] src_const_a [NUM_SRC];

  logic                   req_found;
  logic [ID_W-1:0]        req_sel;
  logic                   last_forced;
  logic                   beat_accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data_a[i]  = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
    assign src_keep_a[i]  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
    assign src_mode_a[i]  = src_mode[2*i +: 2];
    assign src_const_a[i] = src_constant[i*TDATA_WIDTH +: TDATA_WIDTH];
  end

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return ID_W'(sum);
  endfunction

  // Descending scan so the nearest requester after rr_ptr overwrites any farther one.
  always_comb begin : rr_pick
    req_found = 1'b0;
    req_sel   = rr_ptr_q;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (s_axis_tvalid[wrap_add(rr_ptr_q, k)]) begin
        req_found = 1'b1;
        req_sel   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  assign last_forced = (beat_cnt_q == LAST_BEAT);

  always_comb begin : route
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q == ST_XFER) begin
      m_axis_tdata              = src_data_a[grant_id_q];
      m_axis_tkeep              = src_keep_a[grant_id_q];
      m_axis_tvalid             = s_axis_tvalid[grant_id_q];
      m_axis_tlast              = s_axis_tlast[grant_id_q] | last_forced;
      s_axis_tready[grant_id_q] = m_axis_tready;
    end
  end

  assign beat_accept = m_axis_tvalid & m_axis_tready;

  always_comb begin : next_state
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    mode_d     = mode_q;
    const_d    = const_q;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          state_d    = ST_XFER;
          grant_id_d = req_sel;
          mode_d     = src_mode_a[req_sel];
          const_d    = src_const_a[req_sel];
          beat_cnt_d = '0;
        end
      end
      ST_XFER: begin
        if (beat_accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (m_axis_tlast) begin
            state_d  = ST_IDLE;
            rr_ptr_d = wrap_add(grant_id_q, 1);
            // Only a cut made by the length limit is an error; a genuine tlast on the last slot is not.
            err_d    = ~s_axis_tlast[grant_id_q];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      mode_q     <= '0;
      const_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      mode_q     <= mode_d;
      const_q    <= const_d;
      err_q      <= err_d;
    end
  end

  assign m_mode           = mode_q;
  assign m_constant_value = const_q;
  assign grant_id         = grant_id_q;
  assign busy             = (state_q == ST_XFER);
  assign err_overlength   = err_q;

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Bench for axis_stream_arbiter: directed scenario tasks plus a randomized run scored against a
// rule-level arbitration model and per-source in-order data scoreboards.
module tb_axis_stream_arbiter;

  localparam int DW   = 32;
  localparam int NS   = 4;
  localparam int MAXL = 10;
  localparam int IDW  = 2;
  localparam int KW   = DW / 8;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [NS*DW-1:0]  s_axis_tdata = '0;
  logic [NS*KW-1:0]  s_axis_tkeep = '0;
  logic [NS-1:0]     s_axis_tlast = '0;
  logic [NS-1:0]     s_axis_tvalid = '0;
  logic [NS-1:0]     s_axis_tready;
  logic [2*NS-1:0]   src_mode = '0;
  logic [NS*DW-1:0]  src_constant = '0;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [1:0]        m_mode;
  logic [DW-1:0]     m_constant_value;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              err_overlength;

  always #5 aclk = ~aclk;

  axis_stream_arbiter #(
    .TDATA_WIDTH(DW), .NUM_SRC(NS), .MAX_PACKET_LEN(MAXL), .ID_W(IDW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .src_mode(src_mode), .src_constant(src_constant),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_mode(m_mode), .m_constant_value(m_constant_value), .grant_id(grant_id),
    .busy(busy), .err_overlength(err_overlength)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int            grant;
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    mode;
    logic [DW-1:0] cval;
    int            cyc;
  } obs_t;

  beat_t src_q [NS][$];
  beat_t exp_q [NS][$];
  obs_t  out_log [$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  int err_cyc  = -1;
  bit gap_en   = 1'b0;
  logic [NS-1:0] drv_valid = '0;
  logic [NS-1:0] acc_src   = '0;

  logic           o_valid, o_last, o_busy, o_err, o_ready;
  logic [DW-1:0]  o_data, o_const;
  logic [KW-1:0]  o_keep;
  logic [1:0]     o_mode;
  logic [IDW-1:0] o_grant;
  logic [NS-1:0]  o_sready;

  function automatic bit queues_empty();
    for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_beat(input int s, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d; b.keep = '1; b.last = l;
    src_q[s].push_back(b);
  endtask

  // AXI rule: a presented beat stays valid until accepted; new beats may be delayed when gaps are enabled.
  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() == 0) drv_valid[i] = 1'b0;
      else if (!drv_valid[i] && (!gap_en || $urandom_range(3) != 0)) drv_valid[i] = 1'b1;
      s_axis_tvalid[i] = drv_valid[i];
      if (drv_valid[i]) begin
        s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
        s_axis_tkeep[i*KW +: KW] = src_q[i][0].keep;
        s_axis_tlast[i]          = src_q[i][0].last;
      end else begin
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tkeep[i*KW +: KW] = '0;
        s_axis_tlast[i]          = 1'b0;
      end
    end
  endtask

  // One cycle: drive, sample mid-cycle at negedge, then retire accepted source beats just after posedge.
  task automatic tick();
    obs_t ob;
    drive_inputs();
    @(negedge aclk);
    o_valid = m_axis_tvalid; o_last = m_axis_tlast; o_busy = busy; o_err = err_overlength;
    o_ready = m_axis_tready; o_data = m_axis_tdata; o_keep = m_axis_tkeep; o_const = m_constant_value;
    o_mode = m_mode; o_grant = grant_id; o_sready = s_axis_tready;
    acc_src = s_axis_tvalid & s_axis_tready;
    if (o_err) begin err_cnt++; err_cyc = cyc; end
    if (o_valid && o_ready) begin
      ob.grant = int'(o_grant); ob.data = o_data; ob.last = o_last;
      ob.mode = o_mode; ob.cval = o_const; ob.cyc = cyc;
      out_log.push_back(ob);
    end
    @(posedge aclk); #1;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (acc_src[i]) begin
        void'(src_q[i].pop_front());
        drv_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    for (int i = 0; i < NS; i++) src_q[i].delete();
    drv_valid = '0;
    m_axis_tready = 1'b0;
    drive_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk) areset = 1'b0;
    @(posedge aclk); #1;
    out_log.delete();
    err_cnt = 0;
    err_cyc = -1;
  endtask

  task automatic drain(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (queues_empty() && !busy) begin timed_out = 1'b0; break; end
      tick();
    end
    if (queues_empty() && !busy) timed_out = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_axis_tvalid = '1;
    s_axis_tdata = {NS{32'hA5A5_5A5A}};
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    n_checks++;
    if ({busy, m_axis_tvalid, err_overlength} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, m_axis_tvalid, err_overlength});
    else n_pass++;
    n_checks++;
    if (s_axis_tready !== '0) $display("FAIL reset_tready: got %b expected 0000", s_axis_tready);
    else n_pass++;
    n_checks++;
    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== '0) $display("FAIL reset_mdata: got %h/%h/%b expected zeros", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    else n_pass++;
    n_checks++;
    if ({grant_id, m_mode, m_constant_value} !== '0) $display("FAIL reset_latched: got %0d/%0d/%h expected zeros", grant_id, m_mode, m_constant_value);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_single();
    bit to;
    apply_reset();
    m_axis_tready = 1'b1;
    src_mode = 8'b0000_0001;
    push_beat(0, 32'h1234_5678, 1'b1);
    tick();
    n_checks++;
    if ({o_valid, o_busy} !== 2'b00) $display("FAIL single_latency: got valid/busy %b expected 00", {o_valid, o_busy});
    else n_pass++;
    tick();
    n_checks++;
    if ({o_valid, o_last, o_data} !== {2'b11, 32'h1234_5678}) $display("FAIL single_beat: got v%b l%b %h expected v1 l1 12345678", o_valid, o_last, o_data);
    else n_pass++;
    n_checks++;
    if ({o_mode, o_grant, o_sready} !== {2'd1, 2'd0, 4'b0001}) $display("FAIL single_grant: got mode %0d grant %0d tready %b expected 1 0 0001", o_mode, o_grant, o_sready);
    else n_pass++;
    tick();
    n_checks++;
    if ({o_valid, o_busy} !== 2'b00) $display("FAIL single_idle: got valid/busy %b expected 00", {o_valid, o_busy});
    else n_pass++;
    push_beat(0, 32'hA0, 1'b1);
    push_beat(1, 32'hA1, 1'b1);
    tick();
    tick();
    n_checks++;
    if ({o_valid, o_grant} !== {1'b1, 2'd1}) $display("FAIL single_rr_ptr: got valid %b grant %0d expected 1 1", o_valid, o_grant);
    else n_pass++;
    drain(50, to);
    n_checks++;
    if (to || out_log.size() != 3) $display("FAIL single_drain: got timeout %0d beats %0d expected 0 3", to, out_log.size());
    else n_pass++;
  endtask

  task automatic test_fairness();
    bit to;
    int base;
    apply_reset();
    m_axis_tready = 1'b1;
    for (int s = 0; s < NS; s++) begin
      for (int pk = 0; pk < (s == 0 ? 2 : 1); pk++) begin
        push_beat(s, DW'((s << 8) | (pk << 4) | 0), 1'b0);
        push_beat(s, DW'((s << 8) | (pk << 4) | 1), 1'b1);
      end
    end
    drain(200, to);
    n_checks++;
    if (to || out_log.size() != 10) $display("FAIL fair_count: got timeout %0d beats %0d expected 0 10", to, out_log.size());
    else n_pass++;
    if (out_log.size() == 10) begin
      base = out_log[0].cyc;
      for (int p = 0; p < 5; p++) begin
        for (int b = 0; b < 2; b++) begin
          int idx = p * 2 + b;
          int es = p % NS;
          logic [DW-1:0] ed;
          ed = DW'((es << 8) | ((p / NS) << 4) | b);
          n_checks++;
          if (out_log[idx].grant != es || out_log[idx].data !== ed || out_log[idx].last !== (b == 1) ||
              out_log[idx].cyc != base + p * 3 + b)
            $display("FAIL fair_beat%0d: got grant %0d data %h last %b cyc %0d expected %0d %h %b %0d",
                     idx, out_log[idx].grant, out_log[idx].data, out_log[idx].last, out_log[idx].cyc,
                     es, ed, (b == 1), base + p * 3 + b);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_config_latch();
    bit to;
    apply_reset();
    m_axis_tready = 1'b1;
    src_mode[5:4] = 2'd2;
    src_constant[2*DW +: DW] = 32'h5;
    for (int b = 0; b < 3; b++) push_beat(2, DW'(32'hC0 + b), b == 2);
    for (int c = 0; c < 20 && out_log.size() < 3; c++) begin
      tick();
      if (out_log.size() >= 1) begin
        src_constant[2*DW +: DW] = 32'hFFFF_FFFF;
        src_mode[5:4] = 2'd3;
      end
    end
    drain(20, to);
    n_checks++;
    if (to || out_log.size() != 3) $display("FAIL cfg_count: got timeout %0d beats %0d expected 0 3", to, out_log.size());
    else n_pass++;
    for (int i = 0; i < out_log.size(); i++) begin
      n_checks++;
      if (out_log[i].cval !== 32'h5 || out_log[i].mode !== 2'd2 || out_log[i].grant != 2)
        $display("FAIL cfg_beat%0d: got const %h mode %0d grant %0d expected 00000005 2 2", i, out_log[i].cval, out_log[i].mode, out_log[i].grant);
      else n_pass++;
    end
    push_beat(2, 32'hC3, 1'b1);
    drain(20, to);
    n_checks++;
    if (out_log.size() != 4 || out_log[out_log.size()-1].cval !== 32'hFFFF_FFFF || out_log[out_log.size()-1].mode !== 2'd3)
      $display("FAIL cfg_regrant: got beats %0d const %h expected 4 ffffffff", out_log.size(), m_constant_value);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    int n1;
    apply_reset();
    m_axis_tready = 1'b1;
    for (int b = 0; b < 4; b++) push_beat(1, DW'(32'hB0 + b), b == 3);
    for (int c = 0; c < 20 && out_log.size() < 1; c++) tick();
    push_beat(0, 32'hB9, 1'b1);
    m_axis_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({o_valid, o_data, o_grant, o_sready} !== {1'b1, 32'hB1, 2'd1, 4'b0000})
        $display("FAIL bp_hold%0d: got v%b %h grant %0d tready %b expected v1 b1 1 0000", c, o_valid, o_data, o_grant, o_sready);
      else n_pass++;
    end
    m_axis_tready = 1'b1;
    tick();
    n_checks++;
    if ({o_data, o_sready} !== {32'hB1, 4'b0010}) $display("FAIL bp_release: got %h tready %b expected b1 0010", o_data, o_sready);
    else n_pass++;
    drain(50, to);
    n1 = 0;
    foreach (out_log[i]) if (out_log[i].grant == 1) begin
      if (out_log[i].data === DW'(32'hB0 + n1) && out_log[i].last === (n1 == 3)) n1++;
    end
    n_checks++;
    if (to || n1 != 4 || out_log.size() != 5) $display("FAIL bp_total: got timeout %0d src1 beats %0d total %0d expected 0 4 5", to, n1, out_log.size());
    else n_pass++;
    n_checks++;
    if (out_log.size() == 5 && out_log[4].grant != 0) $display("FAIL bp_next: got grant %0d expected 0", out_log[4].grant);
    else n_pass++;
  endtask

  task automatic test_overlength();
    bit to;
    apply_reset();
    m_axis_tready = 1'b1;
    for (int b = 0; b < 12; b++) push_beat(1, DW'(32'h1100 + b), b == 11);
    push_beat(2, 32'h2200, 1'b1);
    drain(200, to);
    n_checks++;
    if (to || out_log.size() != 13) $display("FAIL ovl_count: got timeout %0d beats %0d expected 0 13", to, out_log.size());
    else n_pass++;
    if (out_log.size() == 13) begin
      for (int i = 0; i < 13; i++) begin
        int eg;
        logic [DW-1:0] ed;
        logic el;
        if (i < 10)       begin eg = 1; ed = DW'(32'h1100 + i); el = (i == 9); end
        else if (i == 10) begin eg = 2; ed = 32'h2200;          el = 1'b1;     end
        else              begin eg = 1; ed = DW'(32'h1100 + i - 1); el = (i == 12); end
        n_checks++;
        if (out_log[i].grant != eg || out_log[i].data !== ed || out_log[i].last !== el)
          $display("FAIL ovl_beat%0d: got grant %0d data %h last %b expected %0d %h %b", i, out_log[i].grant, out_log[i].data, out_log[i].last, eg, ed, el);
        else n_pass++;
      end
      n_checks++;
      if (err_cnt != 1 || err_cyc != out_log[9].cyc + 1) $display("FAIL ovl_err: got pulses %0d at %0d expected 1 at %0d", err_cnt, err_cyc, out_log[9].cyc + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    apply_reset();
    m_axis_tready = 1'b1;
    src_mode[7:6] = 2'd1;
    src_constant[3*DW +: DW] = 32'hDEAD_BEEF;
    push_beat(2, 32'h2A, 1'b1);
    drain(20, to);
    for (int b = 0; b < 4; b++) push_beat(3, DW'(32'h30 + b), b == 3);
    for (int c = 0; c < 20 && out_log.size() < 2; c++) tick();
    #2 areset = 1'b1;
    #1;
    n_checks++;
    if ({m_axis_tvalid, s_axis_tready, busy} !== 6'b0) $display("FAIL rstmid_drop: got valid %b tready %b busy %b expected 0", m_axis_tvalid, s_axis_tready, busy);
    else n_pass++;
    n_checks++;
    if ({m_mode, m_constant_value, grant_id} !== '0) $display("FAIL rstmid_latched: got %0d %h %0d expected zeros", m_mode, m_constant_value, grant_id);
    else n_pass++;
    apply_reset();
    m_axis_tready = 1'b1;
    push_beat(3, 32'h33, 1'b1);
    push_beat(0, 32'h03, 1'b1);
    tick();
    tick();
    n_checks++;
    if ({o_valid, o_grant, o_data} !== {1'b1, 2'd0, 32'h03}) $display("FAIL rstmid_first: got v%b grant %0d %h expected v1 0 00000003", o_valid, o_grant, o_data);
    else n_pass++;
    drain(20, to);
  endtask

  task automatic test_random();
    bit mdl_busy, mdl_err, fin;
    int mdl_rr, mdl_gnt, mdl_cnt, t;
    logic [1:0] mdl_mode;
    logic [DW-1:0] mdl_const;
    logic [NS-1:0] e_sready;
    logic e_valid, e_last;
    logic [DW-1:0] e_data;
    logic [KW-1:0] e_keep;
    beat_t b, eb;
    apply_reset();
    gap_en = 1'b1;
    mdl_busy = 0; mdl_err = 0; mdl_rr = 0; mdl_gnt = 0; mdl_cnt = 0; mdl_mode = 0; mdl_const = 0;
    for (int s = 0; s < NS; s++) exp_q[s].delete();
    t = 0;
    while (t < 8000 && !(t >= 2500 && queues_empty() && !busy)) begin
      for (int s = 0; s < NS; s++) begin
        if (t < 2500 && src_q[s].size() < 16 && $urandom_range(9) == 0) begin
          int len = $urandom_range(13, 1);
          for (int k = 0; k < len; k++) begin
            b.data = $urandom; b.keep = KW'($urandom); b.last = (k == len - 1);
            src_q[s].push_back(b);
            exp_q[s].push_back(b);
          end
        end
      end
      if ($urandom_range(3) == 0) begin
        src_mode = 8'($urandom);
        for (int s = 0; s < NS; s++) src_constant[s*DW +: DW] = $urandom;
      end
      m_axis_tready = ($urandom_range(3) != 0);
      tick();
      e_valid = mdl_busy && s_axis_tvalid[mdl_gnt];
      e_last  = mdl_busy && (s_axis_tlast[mdl_gnt] || mdl_cnt == MAXL - 1);
      e_sready = mdl_busy ? (NS'(m_axis_tready) << mdl_gnt) : '0;
      e_data  = mdl_busy ? s_axis_tdata[mdl_gnt*DW +: DW] : '0;
      e_keep  = mdl_busy ? s_axis_tkeep[mdl_gnt*KW +: KW] : '0;
      n_checks++;
      if ({o_valid, o_last, o_sready, o_busy, o_err, o_grant, o_mode} !==
          {e_valid, e_last, e_sready, mdl_busy, mdl_err, IDW'(mdl_gnt), mdl_mode})
        $display("FAIL rnd_ctrl@%0d: got v%b l%b rdy%b busy%b err%b g%0d m%0d expected v%b l%b rdy%b busy%b err%b g%0d m%0d",
                 t, o_valid, o_last, o_sready, o_busy, o_err, o_grant, o_mode,
                 e_valid, e_last, e_sready, mdl_busy, mdl_err, mdl_gnt, mdl_mode);
      else n_pass++;
      n_checks++;
      if ({o_data, o_keep, o_const} !== {e_data, e_keep, mdl_const})
        $display("FAIL rnd_data@%0d: got %h/%h/%h expected %h/%h/%h", t, o_data, o_keep, o_const, e_data, e_keep, mdl_const);
      else n_pass++;
      if (o_valid && o_ready) begin
        n_checks++;
        if (exp_q[o_grant].size() == 0) $display("FAIL rnd_sb@%0d: got beat %h from src %0d expected none", t, o_data, o_grant);
        else begin
          eb = exp_q[o_grant].pop_front();
          if ({o_data, o_keep} !== {eb.data, eb.keep}) $display("FAIL rnd_sb@%0d: got %h/%h expected %h/%h", t, o_data, o_keep, eb.data, eb.keep);
          else n_pass++;
        end
      end
      mdl_err = 1'b0;
      if (!mdl_busy) begin
        for (int k = 0; k < NS; k++) begin
          int idx = (mdl_rr + k) % NS;
          if (s_axis_tvalid[idx]) begin
            mdl_busy = 1'b1; mdl_gnt = idx; mdl_cnt = 0;
            mdl_mode = src_mode[2*idx +: 2];
            mdl_const = src_constant[idx*DW +: DW];
            break;
          end
        end
      end else if (s_axis_tvalid[mdl_gnt] && m_axis_tready) begin
        fin = s_axis_tlast[mdl_gnt] || (mdl_cnt == MAXL - 1);
        mdl_cnt++;
        if (fin) begin
          mdl_busy = 1'b0;
          mdl_err = !s_axis_tlast[mdl_gnt];
          mdl_rr = (mdl_gnt + 1) % NS;
        end
      end
      t++;
    end
    gap_en = 1'b0;
    n_checks++;
    if (t >= 8000) $display("FAIL rnd_timeout: got %0d cycles expected drain before 8000", t);
    else n_pass++;
    for (int s = 0; s < NS; s++) begin
      n_checks++;
      if (exp_q[s].size() != 0) $display("FAIL rnd_leftover_src%0d: got %0d beats undelivered expected 0", s, exp_q[s].size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_config_latch();
    test_backpressure();
    test_overlength();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
